// File: rtl/ica_sample_buffer.sv
// ica_sample_buffer
//
// Ping-pong sample store between the whitening stage and the FastICA engine.
// The writer fills one bank with CH-channel vectors while the reader makes
// one or more full passes over the other bank. A bank is handed back to the
// writer only when the reader releases it.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   wr_valid/ready    write handshake, wr_data = CH packed W-bit samples
//   rd_start          pulse: start one pass over the current read bank
//   rd_release        pulse: give the current read bank back to the writer
//   rd_valid/ready    read handshake, rd_data packed as wr_data
//   rd_last           marks the sample at address DEPTH-1 of a pass
//   rd_busy           a pass is in progress
//   rd_avail          read bank is FULL and idle
//   pass_cnt          completed passes on the read bank (saturating)
//   bank_state        {bank1, bank0}: 0 EMPTY, 1 FILLING, 2 FULL, 3 READING

module ica_sample_buffer #(
    parameter int CH    = 4,
    parameter int W     = 26,
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [CH*W-1:0] wr_data,
    input  logic            rd_start,
    input  logic            rd_release,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic [CH*W-1:0] rd_data,
    output logic            rd_last,
    output logic            rd_busy,
    output logic            rd_avail,
    output logic [7:0]      pass_cnt,
    output logic [3:0]      bank_state
);

    localparam int DW = CH * W;

    typedef enum logic [1:0] {
        B_EMPTY   = 2'd0,
        B_FILLING = 2'd1,
        B_FULL    = 2'd2,
        B_READING = 2'd3
    } bank_t;

    bank_t          bank_q [2];
    bank_t          bank_d [2];
    logic           wb_q, wb_d;
    logic           rb_q, rb_d;
    logic [AW-1:0]  waddr_q, waddr_d;
    logic [AW-1:0]  raddr_q, raddr_d;
    logic           iss_q, iss_d;          // more addresses of this pass to issue
    logic [7:0]     pass_q, pass_d;

    // Pipeline: stage 1 is the RAM output register, stage 2 the output register.
    logic           s1_valid_q, s1_valid_d;
    logic           s1_last_q, s1_last_d;
    logic [DW-1:0]  ram_q;
    logic           rd_valid_q, rd_valid_d;
    logic           rd_last_q, rd_last_d;
    logic [DW-1:0]  rd_data_q, rd_data_d;

    // Both banks live in one array, the bank number is the address MSB.
    logic [DW-1:0]  mem [0:2*DEPTH-1];

    logic           wr_fire;
    logic           rb_full;
    logic           start_acc;
    logic           rel_acc;
    logic           out_free;
    logic           s1_adv;
    logic           issue;
    logic [AW-1:0]  rd_addr;
    logic           pass_end;

    always_comb begin
        wr_ready  = (bank_q[wb_q] == B_EMPTY) || (bank_q[wb_q] == B_FILLING);
        wr_fire   = wr_valid && wr_ready;
        rb_full   = (bank_q[rb_q] == B_FULL);
        start_acc = rd_start && rb_full;
        // rd_start wins over a simultaneous release
        rel_acc   = rd_release && !rd_start && rb_full;
        out_free  = !rd_valid_q || rd_ready;
        s1_adv    = !s1_valid_q || out_free;
        // The pipeline is always empty when a pass starts, so address 0 is
        // issued on the accepting edge itself.
        issue     = start_acc || (iss_q && s1_adv);
        rd_addr   = start_acc ? '0 : raddr_q;
        pass_end  = rd_valid_q && rd_ready && rd_last_q;
    end

    always_comb begin
        bank_d[0]  = bank_q[0];
        bank_d[1]  = bank_q[1];
        wb_d       = wb_q;
        rb_d       = rb_q;
        waddr_d    = waddr_q;
        raddr_d    = raddr_q;
        iss_d      = iss_q;
        pass_d     = pass_q;
        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;
        rd_data_d  = rd_data_q;

        // Write side. The write bank can never be the bank the reader is
        // touching in the same cycle, so both sides update independently.
        if (wr_fire) begin
            waddr_d = waddr_q + AW'(1);
            if (waddr_q == AW'(DEPTH - 1)) begin
                bank_d[wb_q] = B_FULL;
                wb_d         = ~wb_q;
            end else begin
                bank_d[wb_q] = B_FILLING;
            end
        end

        // Address issue
        if (start_acc) begin
            bank_d[rb_q] = B_READING;
            raddr_d      = AW'(1);
            iss_d        = 1'b1;
        end else if (iss_q && s1_adv) begin
            raddr_d = raddr_q + AW'(1);
            if (raddr_q == AW'(DEPTH - 1)) begin
                iss_d = 1'b0;
            end
        end

        if (s1_adv) begin
            s1_valid_d = issue;
            s1_last_d  = issue && (rd_addr == AW'(DEPTH - 1));
        end

        // Output register only moves when empty or consumed, which keeps
        // rd_data/rd_last stable across stalls.
        if (out_free) begin
            rd_valid_d = s1_valid_q;
            rd_last_d  = s1_last_q;
            if (s1_valid_q) begin
                rd_data_d = ram_q;
            end
        end

        if (pass_end) begin
            bank_d[rb_q] = B_FULL;
            if (pass_q != 8'hFF) begin
                pass_d = pass_q + 8'd1;
            end
        end

        if (rel_acc) begin
            bank_d[rb_q] = B_EMPTY;
            rb_d         = ~rb_q;
            pass_d       = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q[0]  <= B_EMPTY;
            bank_q[1]  <= B_EMPTY;
            wb_q       <= 1'b0;
            rb_q       <= 1'b0;
            waddr_q    <= '0;
            raddr_q    <= '0;
            iss_q      <= 1'b0;
            pass_q     <= 8'd0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            bank_q[0]  <= bank_d[0];
            bank_q[1]  <= bank_d[1];
            wb_q       <= wb_d;
            rb_q       <= rb_d;
            waddr_q    <= waddr_d;
            raddr_q    <= raddr_d;
            iss_q      <= iss_d;
            pass_q     <= pass_d;
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Block RAM: one write port, one registered read port with enable.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[{wb_q, waddr_q}] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            ram_q <= mem[{rb_q, rd_addr}];
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_last  = rd_last_q;
    assign rd_data  = rd_data_q;
    assign rd_busy  = (bank_q[rb_q] == B_READING);
    assign rd_avail = rb_full;
    assign pass_cnt = pass_q;

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank_state
        assign bank_state[gi*2 +: 2] = bank_q[gi];
    end

endmodule

// File: tb/tb_ica_sample_buffer.sv
module tb_ica_sample_buffer;

    localparam int CH    = 4;
    localparam int W     = 26;
    localparam int DEPTH = 8;
    localparam int DW    = CH * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          rd_start = 1'b0;
    logic          rd_release = 1'b0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          rd_busy;
    logic          rd_avail;
    logic [7:0]    pass_cnt;
    logic [3:0]    bank_state;

    ica_sample_buffer #(.CH(CH), .W(W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .rd_start   (rd_start),
        .rd_release (rd_release),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .rd_busy    (rd_busy),
        .rd_avail   (rd_avail),
        .pass_cnt   (pass_cnt),
        .bank_state (bank_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: bank contents and states (0 EMPTY,1 FILLING,2 FULL,3 READING)
    logic [DW-1:0] m_mem [2][DEPTH];
    int            m_st [2];
    int            m_wb, m_rb, m_waddr, m_pass;
    bit            end_pending;
    int            pops;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;
    exp_t exp_q [$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_vec();
        logic [DW-1:0] v;
        for (int k = 0; k < CH; k++) v[k*W +: W] = W'($urandom);
        return v;
    endfunction

    function automatic logic [DW-1:0] pat_vec(input int i);
        logic [DW-1:0] v;
        for (int k = 0; k < CH; k++) v[k*W +: W] = W'(i * 16 + k);
        return v;
    endfunction

    function automatic logic [3:0] m_bank_state();
        return {2'(m_st[1]), 2'(m_st[0])};
    endfunction

    task automatic model_reset();
        m_st[0] = 0; m_st[1] = 0;
        m_wb = 0; m_rb = 0; m_waddr = 0; m_pass = 0;
        end_pending = 0;
        exp_q.delete();
    endtask

    // One clock cycle: drive inputs, compare status outputs with the model,
    // take the edge, then advance the model by the spec rules.
    task automatic cycle(input logic wv, input logic [DW-1:0] wd, input logic st,
                         input logic rel, input logic rdy);
        bit wacc, sacc, racc;
        exp_t e;
        wr_valid = wv; wr_data = wd; rd_start = st; rd_release = rel; rd_ready = rdy;
        chk("bank_state", 128'(bank_state), 128'(m_bank_state()));
        chk("wr_ready", 128'(wr_ready), 128'(m_st[m_wb] <= 1));
        chk("rd_avail", 128'(rd_avail), 128'(m_st[m_rb] == 2));
        chk("rd_busy", 128'(rd_busy), 128'(m_st[m_rb] == 3));
        chk("pass_cnt", 128'(pass_cnt), 128'(m_pass));
        wacc = wv && (m_st[m_wb] <= 1);
        sacc = st && (m_st[m_rb] == 2);
        racc = rel && !st && (m_st[m_rb] == 2);
        @(posedge clk);
        if (wacc) begin
            m_mem[m_wb][m_waddr] = wd;
            m_st[m_wb] = 1;
            m_waddr++;
            if (m_waddr == DEPTH) begin
                m_st[m_wb] = 2;
                m_waddr = 0;
                m_wb ^= 1;
            end
        end
        if (end_pending) begin
            m_st[m_rb] = 2;
            if (m_pass < 255) m_pass++;
            end_pending = 0;
        end
        if (sacc) begin
            m_st[m_rb] = 3;
            for (int i = 0; i < DEPTH; i++) begin
                e.data = m_mem[m_rb][i];
                e.last = (i == DEPTH - 1);
                exp_q.push_back(e);
            end
        end
        if (racc) begin
            m_st[m_rb] = 0;
            m_rb ^= 1;
            m_pass = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_valid = 0; rd_start = 0; rd_release = 0; rd_ready = 0; wr_data = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("rst_rd_valid", 128'(rd_valid), 128'(0));
        chk("rst_rd_last", 128'(rd_last), 128'(0));
        chk("rst_rd_data", 128'(rd_data), 128'(0));
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < DEPTH; i++) cycle(1, pat_vec(i), 0, 0, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, '0, 0, 0, 1);
    endtask

    // Scoreboard monitor
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!rd_valid || rd_data !== prev_data || rd_last !== prev_last) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                             rd_valid, rd_data, rd_last, prev_data, prev_last);
                end
            end
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read: data=%h with no sample outstanding", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    $display("read sample data=%h last=%b", rd_data, rd_last);
                    chk("rd_data", 128'(rd_data), 128'(e.data));
                    chk("rd_last", 128'(rd_last), 128'(e.last));
                    if (e.last) end_pending = 1;
                end
                pops++;
            end
            prev_stall = rd_valid && !rd_ready;
            prev_data  = rd_data;
            prev_last  = rd_last;
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] v;
        int base;
        int n;
        pops = 0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        chk("rst_bank_state", 128'(bank_state), 128'(0));
        chk("rst_wr_ready", 128'(wr_ready), 128'(1));

        // Fill bank0 with the i*16+k pattern
        fill_pattern();
        chk("fill0_state", 128'(bank_state), 128'(4'b0010));

        // First pass, rd_ready high: latency 2, exactly DEPTH contiguous samples
        cycle(0, '0, 1, 0, 1);
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("lat_valid_%0d", c), 128'(rd_valid), 128'((c >= 1) && (c <= DEPTH)));
            cycle(0, '0, 0, 0, 1);
        end

        // Second pass with rd_ready toggling, release attempted mid-pass
        cycle(0, '0, 1, 0, 0);
        for (int c = 0; c < 30; c++) cycle(0, '0, 0, (c == 5), (c % 2) == 0);
        idle(2);

        // Fill bank1 with random data including an all-ones vector
        for (int i = 0; i < DEPTH; i++) begin
            v = (i == 2) ? '1 : rand_vec();
            cycle(1, v, 0, 0, 1);
        end
        for (int i = 0; i < 3; i++) cycle(1, rand_vec(), 0, 0, 1);
        cycle(0, '0, 0, 1, 1);
        for (int i = 0; i < DEPTH; i++) cycle(1, rand_vec(), 0, 0, 1);

        // Start and release together on the FULL bank1
        cycle(0, '0, 1, 1, 1);
        idle(12);
        cycle(0, '0, 0, 1, 1);

        // Randomised traffic
        for (int c = 0; c < 300; c++) begin
            cycle($urandom_range(0, 3) != 0, rand_vec(), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
        end
        idle(30);

        // Reset during a pass at sample 3 with a half-filled bank
        do_reset();
        fill_pattern();
        for (int i = 0; i < DEPTH / 2; i++) cycle(1, rand_vec(), 0, 0, 1);
        cycle(0, '0, 1, 0, 1);
        base = pops;
        n = 0;
        while (pops < base + 3 && n < 20) begin
            cycle(0, '0, 0, 0, 1);
            n++;
        end
        chk("reach_sample3", 128'(pops - base >= 3), 128'(1));
        do_reset();
        chk("midrst_bank_state", 128'(bank_state), 128'(0));
        chk("midrst_wr_ready", 128'(wr_ready), 128'(1));
        chk("midrst_pass_cnt", 128'(pass_cnt), 128'(0));
        chk("midrst_rd_busy", 128'(rd_busy), 128'(0));
        chk("midrst_rd_avail", 128'(rd_avail), 128'(0));

        // Clean fill and read after reset
        fill_pattern();
        cycle(0, '0, 1, 0, 1);
        idle(12);

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            cycle(0, '0, 0, 0, 1);
            n++;
        end
        chk("queue_drained", 128'(exp_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ica_sample_buffer.md
Name: ica_sample_buffer

Overview:
- Parametrised double-banked (ping-pong) sample store between the whitening stage and the FastICA iteration engine.
- The whitening side streams CH-channel whitened vectors into one bank while the FastICA side reads the other bank.
- Readout supports repeated full passes over the same bank, as FastICA needs for each weight-update iteration, until the reader explicitly releases the bank.
- Generalises the fixed 4-channel, 26-bit single-bank RAM to any channel count, width and depth, and adds flow control and multi-pass readout.

Parameters:
- CH, 4, number of channels (whitened signals) per sample vector
- W, 26, signed width of each channel sample
- DEPTH, 4096, samples per bank; must be a power of two, minimum 4
- AW, $clog2(DEPTH), address width (derived; do not override)

Ports:
- clk  in  1  system clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  write vector present
- wr_ready  out  1  buffer can accept a write this cycle
- wr_data  in  CH*W  channel k at bits [k*W +: W], two's complement
- rd_start  in  1  one-cycle pulse: begin one pass over the current read bank
- rd_release  in  1  one-cycle pulse: free the current read bank for writing
- rd_valid  out  1  rd_data holds a valid sample
- rd_ready  in  1  reader consumes the sample
- rd_data  out  CH*W  same packing as wr_data
- rd_last  out  1  qualifies the sample at address DEPTH-1 of a pass
- rd_busy  out  1  a pass is in progress
- rd_avail  out  1  current read bank is FULL and idle, so rd_start will be accepted
- pass_cnt  out  8  completed passes on the current read bank; saturates at 255
- bank_state  out  4  {bank1[1:0], bank0[1:0]}: 0=EMPTY, 1=FILLING, 2=FULL, 3=READING

Behaviour:
Reset (rst=1 at a clk edge, including mid-pass or mid-fill):
- Both banks EMPTY; write bank wb=0; read bank rb=0; write and read addresses 0.
- wr_ready=1 on the first cycle after reset deasserts.
- rd_valid, rd_last, rd_busy, rd_avail = 0; rd_data = 0; pass_cnt = 0.
- Partially written data is discarded.

Write side:
- wr_ready = 1 when bank[wb] is EMPTY or FILLING.
- A write occurs on each cycle with wr_valid && wr_ready. It stores at waddr, increments waddr, and moves the bank from EMPTY to FILLING.
- The write at waddr = DEPTH-1 sets the bank to FULL, wraps waddr to 0 and toggles wb.
- If the other bank is not EMPTY, wr_ready drops the next cycle. No write is ever dropped or overwrites a non-empty bank.
- wr_data is ignored when wr_ready = 0.

Read side:
- rd_avail = 1 when bank[rb] is FULL.
- rd_start is accepted only when rd_avail = 1. Accepting it sets the bank to READING, rd_busy = 1 and raddr = 0. rd_start in any other state is ignored.
- rd_valid first asserts on the 2nd cycle after the accepted rd_start (synchronous-read RAM plus output register).
- rd_data and rd_last hold stable while rd_valid && !rd_ready.
- With rd_ready held high, one sample is delivered per cycle with no bubbles.
- Samples appear in write order, addresses 0..DEPTH-1.
- On the handshake of the rd_last sample, in the same edge: rd_busy = 0, bank returns to FULL, pass_cnt increments (saturating). rd_valid = 0 on the next cycle unless a new pass has started.
- rd_release is accepted only when bank[rb] is FULL and not READING. Accepting it sets the bank to EMPTY, toggles rb and clears pass_cnt to 0. It is ignored otherwise, including during a pass.
- rd_start and rd_release asserted in the same cycle: rd_start wins and rd_release is ignored.

Simultaneous events:
- A write completing a bank and a release of the other bank in the same cycle are independent. Both take effect, so wr_ready stays 1.
- When wb == rb, the writer is filling the bank the reader is waiting on. rd_avail rises on the cycle after the final write.

Test Plan:
- DEPTH=8, CH=4, W=26. Reset, then write 8 vectors with channel k of sample i = i*16+k → bank_state=4'b0010, rd_avail=1, wr_ready stays 1 (bank1 EMPTY).
- rd_start with rd_ready=1 → rd_valid high 2 cycles later for exactly 8 cycles, data 0x00,0x10,…,0x70 (per channel +k), rd_last only on the 8th, pass_cnt=1.
- Second pass with rd_ready toggling 1010… → identical data sequence, held stable during stalls, pass_cnt=2. A rd_release mid-pass is ignored and bank0 stays READING.
- Fill both banks, then hold wr_valid=1 → wr_ready=0 and no state change. rd_release → wb filling resumes into bank0 the next cycle, pass_cnt=0, rb=1, rd_avail=1.
- rd_start and rd_release asserted in the same cycle on a FULL bank → a pass starts and the bank is not freed. Negative samples (-1 = all ones) are read back bit-exact.
- Assert rst during a pass at sample 3 and during a half-filled bank → next cycle all outputs 0, bank_state=0, wr_ready=1. A subsequent 8-sample fill and read is correct.
